// File: rtl/instr_encoder_if.sv
// Instruction encoder bus: upstream field handshake plus the write port into
// instruction memory. The master side is the environment (field source and
// memory); the slave side is the encoder.
interface instr_encoder_if #(
    parameter int n  = 32,
    parameter int AW = 8
) ();
    logic          start_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [2:0]    fmt_i;
    logic [4:0]    opcode_i;
    logic [4:0]    rd_addr_i;
    logic [4:0]    rs1_addr_i;
    logic [4:0]    rs2_addr_i;
    logic [3:0]    alu_op_i;
    logic [n-1:0]  imm_i;
    logic          last_i;
    logic          mem_wr_o;
    logic          mem_ready_i;
    logic [AW+1:0] mem_addr_o;
    logic [n-1:0]  mem_wdata_o;
    logic [AW:0]   count_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    modport slave (
        input  start_i, in_valid_i, fmt_i, opcode_i, rd_addr_i, rs1_addr_i,
               rs2_addr_i, alu_op_i, imm_i, last_i, mem_ready_i,
        output in_ready_o, mem_wr_o, mem_addr_o, mem_wdata_o, count_o,
               busy_o, done_o, err_o
    );

    modport master (
        output start_i, in_valid_i, fmt_i, opcode_i, rd_addr_i, rs1_addr_i,
               rs2_addr_i, alu_op_i, imm_i, last_i, mem_ready_i,
        input  in_ready_o, mem_wr_o, mem_addr_o, mem_wdata_o, count_o,
               busy_o, done_o, err_o
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs decoded instruction fields into 32-bit
// words and streams them into instruction memory, one word per cycle, with a
// single registered output stage held stable under memory back-pressure.
module instr_encoder #(
    parameter int n     = 32,
    parameter int DEPTH = 256
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    instr_encoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t       state;
    logic [AW:0]  count;
    logic [n-1:0] wdata;
    logic [n-1:0] wdata_next;
    logic [31:0]  enc;
    logic         mem_wr;
    logic         busy;
    logic         done;
    logic         err;
    logic         full;
    logic         in_ready;
    logic         accept;
    logic         wr_fire;
    logic         legal;

    // Occupancy counts the word sitting in the output stage as well, so the
    // last free slot can never be claimed twice while a write is in flight.
    assign full     = ({1'b0, count} + (AW+2)'(mem_wr)) >= (AW+2)'(DEPTH);
    assign in_ready = (state == RUN) && !full && (!mem_wr || bus.mem_ready_i);
    assign accept   = bus.in_valid_i && in_ready;
    assign wr_fire  = mem_wr && bus.mem_ready_i;
    assign legal    = (bus.fmt_i <= 3'd5);

    // Pack the fields of the current beat according to its format.
    always_comb begin
        logic [2:0]    f3;
        logic          f7b;
        logic [6:0]    op7;
        logic [4:0]    rd;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [31:0]   imm;
        f3  = bus.alu_op_i[2:0];
        f7b = bus.alu_op_i[3];
        op7 = {bus.opcode_i, 2'b11};
        rd  = bus.rd_addr_i;
        rs1 = bus.rs1_addr_i;
        rs2 = bus.rs2_addr_i;
        imm = bus.imm_i[31:0];
        enc = '0;
        case (bus.fmt_i)
            3'd0: enc = {1'b0, f7b, 5'b0, rs2, rs1, f3, rd, op7};
            3'd1: begin
                // Shift-immediates carry funct7 in the upper bits and a
                // 5-bit shift amount in place of the rest of the immediate.
                if (f3 == 3'b001 || f3 == 3'b101)
                    enc = {1'b0, f7b, 5'b0, imm[4:0], rs1, f3, rd, op7};
                else
                    enc = {imm[11:0], rs1, f3, rd, op7};
            end
            3'd2: enc = {imm[11:5], rs2, rs1, f3, imm[4:0], op7};
            3'd3: enc = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op7};
            3'd4: enc = {imm[31:12], rd, op7};
            3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op7};
            default: enc = '0;
        endcase
        wdata_next        = '0;
        wdata_next[31:0]  = enc;
    end

    // Session FSM, output stage and write accounting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            count  <= '0;
            wdata  <= '0;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (wr_fire) begin
                mem_wr <= 1'b0;
                count  <= count + 1'b1;
            end
            // A new beat refills the stage on the same edge the old word
            // leaves it, giving one word per cycle under a ready memory.
            if (accept && legal) begin
                mem_wr <= 1'b1;
                wdata  <= wdata_next;
            end
            if (accept && !legal)
                err <= 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        state <= RUN;
                        count <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept && bus.last_i) begin
                        state <= DRAIN;
                    end else if (count == (AW+1)'(DEPTH)) begin
                        // Memory exhausted before the final beat: stop
                        // rather than wrap onto earlier words.
                        state <= DONE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!mem_wr || wr_fire) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.mem_wr_o    = mem_wr;
    assign bus.mem_addr_o  = {count[AW-1:0], 2'b00};
    assign bus.mem_wdata_o = wdata;
    assign bus.count_o     = count;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done;
    assign bus.err_o       = err;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors, back-pressure, illegal formats,
// capacity overflow on a small instance, reset abort and a randomized stream
// checked against a field-packing model built from shifts and masks.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if #(.n(32), .AW(8)) ifa ();
    instr_encoder_if #(.n(32), .AW(2)) ifb ();

    instr_encoder #(.n(32), .DEPTH(256)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
    instr_encoder #(.n(32), .DEPTH(4))   dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu;
        logic [31:0] imm;
        bit          last;
    } beat_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    bit          rand_rdy = 0;
    wr_t         obs_q[$];
    logic [31:0] exp_q[$];
    int          obs_base = 0;
    int          b_writes = 0;

    // Record every completed memory handshake as seen from outside the DUT.
    always @(negedge clk) begin
        if (rst_n && ifa.mem_wr_o && ifa.mem_ready_i)
            obs_q.push_back('{ifa.mem_addr_o, ifa.mem_wdata_o});
        if (rst_n && ifb.mem_wr_o && ifb.mem_ready_i)
            b_writes <= b_writes + 1;
    end

    function automatic beat_t mk(input int f, input int op, input int rd, input int rs1,
                                 input int rs2, input int alu, input logic [31:0] imm, input bit last);
        beat_t b;
        b.fmt = 3'(f); b.op = 5'(op); b.rd = 5'(rd); b.rs1 = 5'(rs1);
        b.rs2 = 5'(rs2); b.alu = 4'(alu); b.imm = imm; b.last = last;
        return b;
    endfunction

    // Reference word: each field is placed at its bit position arithmetically.
    function automatic logic [31:0] ref_enc(input beat_t b);
        int unsigned w, f3, f7, imm, rd, r1, r2;
        imm = b.imm; f3 = b.alu % 8; f7 = b.alu / 8;
        rd = b.rd; r1 = b.rs1; r2 = b.rs2;
        w = 3 + 4 * int'(b.op);
        case (b.fmt)
            3'd0: w += (rd << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20) + (f7 << 30);
            3'd1: if (f3 == 1 || f3 == 5)
                      w += (rd << 7) + (f3 << 12) + (r1 << 15) + ((imm % 32) << 20) + (f7 << 30);
                  else
                      w += (rd << 7) + (f3 << 12) + (r1 << 15) + ((imm % 4096) << 20);
            3'd2: w += ((imm % 32) << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20) + (((imm >> 5) % 128) << 25);
            3'd3: w += (((imm >> 11) & 1) << 7) + (((imm >> 1) & 15) << 8) + (f3 << 12) + (r1 << 15)
                     + (r2 << 20) + (((imm >> 5) & 63) << 25) + (((imm >> 12) & 1) << 31);
            3'd4: w += (rd << 7) + (imm & 32'hFFFFF000);
            3'd5: w += (rd << 7) + (((imm >> 12) & 255) << 12) + (((imm >> 11) & 1) << 20)
                     + (((imm >> 1) & 1023) << 21) + (((imm >> 20) & 1) << 31);
            default: w = 0;
        endcase
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) ifa.mem_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive_fields(input beat_t b);
        ifa.fmt_i = b.fmt; ifa.opcode_i = b.op; ifa.rd_addr_i = b.rd;
        ifa.rs1_addr_i = b.rs1; ifa.rs2_addr_i = b.rs2; ifa.alu_op_i = b.alu;
        ifa.imm_i = b.imm; ifa.last_i = b.last;
    endtask

    task automatic send_beat(input beat_t b, output int cyc);
        bit acc = 0;
        cyc = 0;
        drive_fields(b);
        ifa.in_valid_i = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (ifa.in_ready_o) acc = 1;
            step();
            cyc++;
        end
        ifa.in_valid_i = 1'b0;
        ifa.last_i = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL beat_accept: got no accept within 200 cycles, want accept");
        end else if (b.fmt <= 3'd5) begin
            exp_q.push_back(ref_enc(b));
        end
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (ifa.done_o) got = 1;
            step();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_done: got done_o=0 after 500 cycles, want 1");
        end
    endtask

    task automatic begin_session();
        exp_q.delete();
        obs_base = obs_q.size();
        ifa.start_i = 1'b1;
        step();
        ifa.start_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        @(negedge clk);
        checks++; if (ifa.in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", ifa.in_ready_o); end
        checks++; if (ifa.mem_wr_o !== 1'b0) begin errors++; $display("FAIL rst_mem_wr: got %b want 0", ifa.mem_wr_o); end
        checks++; if ({ifa.busy_o, ifa.done_o, ifa.err_o} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {ifa.busy_o, ifa.done_o, ifa.err_o}); end
        checks++; if (ifa.mem_addr_o !== 10'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", ifa.mem_addr_o); end
        checks++; if (ifa.mem_wdata_o !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h want 0", ifa.mem_wdata_o); end
        checks++; if (ifa.count_o !== 9'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", ifa.count_o); end
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checks++; if ({ifa.in_ready_o, ifa.busy_o} !== 2'b00) begin errors++; $display("FAIL idle_outputs: got %b want 00", {ifa.in_ready_o, ifa.busy_o}); end
        step();
    endtask

    task automatic test_known_vectors();
        logic [31:0] want [4] = '{32'h002081B3, 32'h402081B3, 32'h00500093, 32'h123452B7};
        int c;
        begin_session();
        send_beat(mk(0, 5'b01100, 3, 1, 2, 0, 0, 0), c);
        send_beat(mk(0, 5'b01100, 3, 1, 2, 8, 0, 0), c);
        send_beat(mk(1, 5'b00100, 1, 0, 0, 0, 5, 0), c);
        send_beat(mk(4, 5'b01101, 5, 0, 0, 0, 32'h12345000, 1), c);
        wait_done();
        checks++;
        if (obs_q.size() - obs_base != 4) begin
            errors++; $display("FAIL known_nwrites: got %0d want 4", obs_q.size() - obs_base);
        end else for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_q[obs_base+i].addr !== 10'(4*i) || obs_q[obs_base+i].data !== want[i]) begin
                errors++; $display("FAIL known_word%0d: got %h@%h want %h@%h", i, obs_q[obs_base+i].data, obs_q[obs_base+i].addr, want[i], 10'(4*i));
            end
        end
        checks++; if (ifa.count_o !== 9'd4 || ifa.busy_o !== 1'b0 || ifa.err_o !== 1'b0) begin errors++; $display("FAIL known_status: got count=%0d busy=%b err=%b want 4 0 0", ifa.count_o, ifa.busy_o, ifa.err_o); end
    endtask

    task automatic test_branch_jump();
        logic [31:0] want [2] = '{32'h00208463, 32'h010000EF};
        int c;
        begin_session();
        send_beat(mk(3, 5'b11000, 0, 1, 2, 0, 8, 0), c);
        send_beat(mk(5, 5'b11011, 1, 0, 0, 0, 16, 1), c);
        wait_done();
        checks++;
        if (obs_q.size() - obs_base != 2) begin
            errors++; $display("FAIL bj_nwrites: got %0d want 2", obs_q.size() - obs_base);
        end else for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_q[obs_base+i].addr !== 10'(4*i) || obs_q[obs_base+i].data !== want[i]) begin
                errors++; $display("FAIL bj_word%0d: got %h@%h want %h@%h", i, obs_q[obs_base+i].data, obs_q[obs_base+i].addr, want[i], 10'(4*i));
            end
        end
        checks++; if (ifa.done_o !== 1'b1 || ifa.count_o !== 9'd2) begin errors++; $display("FAIL bj_status: got done=%b count=%0d want 1 2", ifa.done_o, ifa.count_o); end
    endtask

    task automatic test_backpressure();
        beat_t bs [6];
        int c;
        for (int i = 0; i < 6; i++) bs[i] = mk(0, 5'b01100, i + 1, i + 2, i + 3, i, 0, i == 5);
        rand_rdy = 0;
        ifa.mem_ready_i = 1'b1;
        begin_session();
        send_beat(bs[0], c);
        ifa.mem_ready_i = 1'b0;
        drive_fields(bs[1]);
        ifa.in_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ifa.in_ready_o !== 1'b0 || ifa.mem_wr_o !== 1'b1 || ifa.mem_addr_o !== 10'd0 || ifa.mem_wdata_o !== ref_enc(bs[0])) begin
                errors++; $display("FAIL bp_hold%0d: got rdy=%b wr=%b %h@%h want 0 1 %h@000", k, ifa.in_ready_o, ifa.mem_wr_o, ifa.mem_wdata_o, ifa.mem_addr_o, ref_enc(bs[0]));
            end
            step();
        end
        ifa.mem_ready_i = 1'b1;
        for (int i = 1; i < 6; i++) begin
            send_beat(bs[i], c);
            checks++; if (c !== 1) begin errors++; $display("FAIL bp_stream%0d: got %0d cycles want 1", i, c); end
        end
        wait_done();
        checks++;
        if (obs_q.size() - obs_base != exp_q.size()) begin
            errors++; $display("FAIL bp_nwrites: got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
        end else for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[obs_base+i].addr !== 10'(4*i) || obs_q[obs_base+i].data !== exp_q[i]) begin
                errors++; $display("FAIL bp_word%0d: got %h@%h want %h@%h", i, obs_q[obs_base+i].data, obs_q[obs_base+i].addr, exp_q[i], 10'(4*i));
            end
        end
    endtask

    task automatic test_illegal_fmt();
        int c;
        begin_session();
        send_beat(mk(0, 5'b01100, 7, 8, 9, 2, 0, 0), c);
        send_beat(mk(6, 5'b01100, 1, 1, 1, 0, 0, 0), c);
        @(negedge clk);
        checks++; if (ifa.err_o !== 1'b1 || ifa.mem_wr_o !== 1'b0) begin errors++; $display("FAIL ill_err: got err=%b wr=%b want 1 0", ifa.err_o, ifa.mem_wr_o); end
        step();
        send_beat(mk(7, 5'b01100, 1, 1, 1, 0, 0, 1), c);
        wait_done();
        checks++;
        if (obs_q.size() - obs_base != 1 || obs_q[obs_base].data !== exp_q[0]) begin
            errors++; $display("FAIL ill_writes: got %0d writes want 1 of %h", obs_q.size() - obs_base, exp_q[0]);
        end
        checks++; if (ifa.count_o !== 9'd1 || ifa.err_o !== 1'b1) begin errors++; $display("FAIL ill_status: got count=%0d err=%b want 1 1", ifa.count_o, ifa.err_o); end
    endtask

    task automatic test_random_stream();
        beat_t b;
        int c;
        rand_rdy = 1;
        begin_session();
        for (int k = 0; k < 40; k++) begin
            b = mk($urandom_range(0, 5), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, k == 39);
            ifa.start_i = (k == 20);
            send_beat(b, c);
            ifa.start_i = 1'b0;
            if ($urandom_range(0, 3) == 0) step();
        end
        wait_done();
        rand_rdy = 0;
        ifa.mem_ready_i = 1'b1;
        checks++;
        if (obs_q.size() - obs_base != exp_q.size()) begin
            errors++; $display("FAIL rnd_nwrites: got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
        end else for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[obs_base+i].addr !== 10'(4*i) || obs_q[obs_base+i].data !== exp_q[i]) begin
                errors++; $display("FAIL rnd_word%0d: got %h@%h want %h@%h", i, obs_q[obs_base+i].data, obs_q[obs_base+i].addr, exp_q[i], 10'(4*i));
            end
        end
        checks++; if (ifa.count_o !== 9'd40 || ifa.err_o !== 1'b0) begin errors++; $display("FAIL rnd_status: got count=%0d err=%b want 40 0", ifa.count_o, ifa.err_o); end
    endtask

    task automatic test_full();
        int base, accepted = 0;
        bit acc;
        base = b_writes;
        ifb.mem_ready_i = 1'b1;
        ifb.start_i = 1'b1;
        step();
        ifb.start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ifb.fmt_i = 3'd0; ifb.opcode_i = 5'b01100; ifb.rd_addr_i = 5'(k + 1);
            ifb.last_i = (k == 4);
            ifb.in_valid_i = 1'b1;
            acc = 0;
            for (int i = 0; i < 20 && !acc; i++) begin
                @(negedge clk);
                if (ifb.in_ready_o) acc = 1;
                step();
            end
            if (acc) accepted++;
        end
        ifb.in_valid_i = 1'b0;
        ifb.last_i = 1'b0;
        @(negedge clk);
        checks++; if (accepted !== 4) begin errors++; $display("FAIL full_accepts: got %0d want 4", accepted); end
        checks++; if (b_writes - base !== 4) begin errors++; $display("FAIL full_writes: got %0d want 4", b_writes - base); end
        checks++; if ({ifb.err_o, ifb.done_o, ifb.busy_o, ifb.in_ready_o} !== 4'b1100) begin errors++; $display("FAIL full_flags: got err,done,busy,rdy=%b want 1100", {ifb.err_o, ifb.done_o, ifb.busy_o, ifb.in_ready_o}); end
        checks++; if (ifb.count_o !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", ifb.count_o); end
        step();
    endtask

    task automatic test_reset_abort();
        beat_t b;
        int c, n_before;
        rand_rdy = 0;
        ifa.mem_ready_i = 1'b0;
        begin_session();
        send_beat(mk(2, 5'b01000, 0, 3, 4, 2, 32'h7F4, 0), c);
        #1;
        checks++; if (ifa.mem_wr_o !== 1'b1) begin errors++; $display("FAIL abort_pending: got wr=%b want 1", ifa.mem_wr_o); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ifa.in_ready_o, ifa.mem_wr_o, ifa.busy_o, ifa.done_o, ifa.err_o} !== 5'b0) begin errors++; $display("FAIL abort_flags: got %b want 00000", {ifa.in_ready_o, ifa.mem_wr_o, ifa.busy_o, ifa.done_o, ifa.err_o}); end
        checks++; if (ifa.mem_addr_o !== 10'd0 || ifa.mem_wdata_o !== 32'd0 || ifa.count_o !== 9'd0) begin errors++; $display("FAIL abort_bus: got %h@%h cnt=%0d want 0", ifa.mem_wdata_o, ifa.mem_addr_o, ifa.count_o); end
        n_before = obs_q.size();
        ifa.mem_ready_i = 1'b1;
        repeat (3) step();
        checks++; if (obs_q.size() !== n_before) begin errors++; $display("FAIL abort_dropped: got %0d writes want 0", obs_q.size() - n_before); end
        rst_n = 1'b1;
        step();
        begin_session();
        b = mk(1, 5'b00100, 9, 10, 0, 5, 32'h0000040A, 1);
        send_beat(b, c);
        wait_done();
        checks++;
        if (obs_q.size() - obs_base != 1 || obs_q[obs_base].addr !== 10'd0 || obs_q[obs_base].data !== exp_q[0]) begin
            errors++; $display("FAIL abort_restart: got %0d writes want 1 of %h@000", obs_q.size() - obs_base, exp_q[0]);
        end
    endtask

    initial begin
        ifa.start_i = 0; ifa.in_valid_i = 0; ifa.fmt_i = 0; ifa.opcode_i = 0; ifa.rd_addr_i = 0;
        ifa.rs1_addr_i = 0; ifa.rs2_addr_i = 0; ifa.alu_op_i = 0; ifa.imm_i = 0; ifa.last_i = 0;
        ifa.mem_ready_i = 1;
        ifb.start_i = 0; ifb.in_valid_i = 0; ifb.fmt_i = 0; ifb.opcode_i = 0; ifb.rd_addr_i = 0;
        ifb.rs1_addr_i = 0; ifb.rs2_addr_i = 0; ifb.alu_op_i = 0; ifb.imm_i = 0; ifb.last_i = 0;
        ifb.mem_ready_i = 1;
        test_reset();
        test_known_vectors();
        test_branch_jump();
        test_backpressure();
        test_illegal_fmt();
        test_random_stream();
        test_full();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter n, default 32, instruction/data width.
REQ-002 Parameter DEPTH, default 256, instruction-memory capacity in words (power of 2); AW = log2(DEPTH).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  begin a new program session; write pointer cleared.
REQ-006 in_valid_i  input  1  instruction fields valid.
REQ-007 in_ready_o  output  1  encoder accepts fields this cycle.
REQ-008 fmt_i  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 illegal.
REQ-009 opcode_i  input  5  instr[6:2]; instr[1:0] fixed 2'b11.
REQ-010 rd_addr_i, rs1_addr_i, rs2_addr_i  input  5 each  register fields.
REQ-011 alu_op_i  input  4  {funct7[5], funct3}.
REQ-012 imm_i  input  n  immediate, byte-offset form as decoder reconstructs it.
REQ-013 last_i  input  1  marks final instruction of the session.
REQ-014 mem_wr_o  output  1  write request to instruction memory.
REQ-015 mem_ready_i  input  1  memory accepts write this cycle.
REQ-016 mem_addr_o  output  AW+2  byte address = {wr_ptr, 2'b00}.
REQ-017 mem_wdata_o  output  n  encoded instruction.
REQ-018 count_o  output  AW+1  words written this session.
REQ-019 busy_o, done_o, err_o  output  1 each  session active, session complete, error sticky.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start_i; RUN->DRAIN on accepting last_i beat; DRAIN->DONE when pending write accepted; DONE->RUN on start_i (pointer, count, err cleared).
REQ-021 start_i in RUN or DRAIN is ignored.
REQ-022 in_ready_o = (state==RUN) && !full && (!mem_wr_o || mem_ready_i); combinational, no loop through in_valid_i.
REQ-023 Beat accepted when in_valid_i && in_ready_o; encoded word registered into output stage on that edge; mem_wr_o high from next cycle, held stable (addr, data) until mem_ready_i.
REQ-024 Throughput one word/cycle when mem_ready_i held high; latency accept->mem_wr_o = 1 cycle.
REQ-025 R: {0, alu_op[3], 5'b0, rs2, rs1, alu_op[2:0], rd, opcode, 2'b11}.
REQ-026 I: {imm[11:0], rs1, f3, rd, op, 11}; when f3 is 001 or 101, bits[31:25] = {0, alu_op[3], 5'b0}, bits[24:20] = imm[4:0].
REQ-027 S: {imm[11:5], rs2, rs1, f3, imm[4:0], op, 11}.
REQ-028 B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op, 11}.
REQ-029 U: {imm[31:12], rd, op, 11}.  J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op, 11}.
REQ-030 Illegal fmt: beat accepted, no write, err_o set; last_i on such a beat still moves FSM to DRAIN.
REQ-031 wr_ptr, count_o increment on each accepted memory write; full when count_o==DEPTH.
REQ-032 Full in RUN: in_ready_o low, err_o set, FSM -> DONE (no wrap-around, no overwrite).
REQ-033 busy_o = RUN or DRAIN; done_o = DONE.

Reset
REQ-034 rst_ni low: state IDLE; mem_wr_o, in_ready_o, busy_o, done_o, err_o = 0; mem_addr_o, mem_wdata_o, count_o = 0.
REQ-035 Reset mid-session aborts immediately; pending write dropped, no partial handshake completes.

Verification
REQ-036 start; R fmt, op=5'b01100, rd=3, rs1=1, rs2=2, alu_op=0 -> mem_wdata_o=0x002081B3 at addr 0; alu_op=4'b1000 -> 0x402081B3 at addr 4.
REQ-037 I addi rd=1, rs1=0, imm=5 -> 0x00500093; U lui rd=5, imm=0x12345000 -> 0x123452B7.
REQ-038 B beq rs1=1, rs2=2, imm=8 -> 0x00208463; J jal rd=1, imm=16 (last_i) -> 0x010000EF, done_o=1, count_o=2.
REQ-039 mem_ready_i low 3 cycles with streaming input -> in_ready_o low, addr/data stable, no beat lost or duplicated.
REQ-040 DEPTH=4, send 5 beats -> 4 writes, err_o=1, done_o=1; fmt=6 beat -> err_o=1, no write.
REQ-041 rst_ni low while mem_wr_o high -> all outputs 0 asynchronously; restart writes at addr 0.
